obi_slave_mem: RTL and testbench

- OBI responder (target) with a small word-addressed memory behind it.
- It accepts address-phase requests from an OBI master, such as the SPI-slave bus plug, and inserts a configurable number of grant wait states.
- Writes honour byte enables. Read data, or a write acknowledge, comes back on the response channel after a fixed latency.
- Used as the bus-side counterpart of the SPI slave in block-level and system-level benches, and as a scratch memory in small SoCs.

---
 rtl/obi_slave_mem_pkg.sv | 19 +
 rtl/obi_slave_mem_if.sv | 27 ++
 rtl/obi_slave_mem_resp_pipe.sv | 24 ++
 rtl/obi_slave_mem.sv | 92 +++++++++
 tb/tb_obi_slave_mem.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/obi_slave_mem_pkg.sv
// Shared types and constants for the OBI responder memory and its response pipeline.
package obi_pkg;

    localparam int          OBI_BE_W     = 4;
    localparam logic [31:0] OBI_ERR_DATA = 32'h0;
    localparam int          WAIT_CNT_W   = 4;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic        err;
    } resp_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } wait_state_e;

endpackage

// File: rtl/obi_slave_mem_if.sv
// OBI address-phase and response-channel signals between a master and a responder.
interface obi_slave_mem_if import obi_pkg::*; #(
    parameter int OBI_ADDR_WIDTH = 32,
    parameter int OBI_DATA_WIDTH = 32
);

    logic                      req;
    logic                      gnt;
    logic [OBI_ADDR_WIDTH-1:0] addr;
    logic                      we;
    logic [OBI_DATA_WIDTH-1:0] w_data;
    logic [OBI_BE_W-1:0]       be;
    logic                      r_valid;
    logic [OBI_DATA_WIDTH-1:0] r_data;
    logic                      r_err;

    modport master (
        output req, addr, we, w_data, be,
        input  gnt, r_valid, r_data, r_err
    );

    modport slave (
        input  req, addr, we, w_data, be,
        output gnt, r_valid, r_data, r_err
    );

endinterface

// File: rtl/obi_slave_mem_resp_pipe.sv
// In-order response shift pipeline; every stage resets to an empty, all-zero response.
module obi_resp_pipe import obi_pkg::*; #(
    parameter int LATENCY = 1
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  resp_t resp_i,
    output resp_t resp_o
);

    resp_t stage_q [LATENCY];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= resp_i;
            for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign resp_o = stage_q[LATENCY-1];

endmodule

// File: rtl/obi_slave_mem.sv
// OBI responder with grant wait states, a byte-enabled word memory and a fixed-latency response.
module obi_slave_mem import obi_pkg::*; #(
    parameter int                        OBI_ADDR_WIDTH = 32,
    parameter int                        OBI_DATA_WIDTH = 32,
    parameter int                        MEM_WORDS      = 256,
    parameter logic [OBI_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                        WAIT_STATES    = 0,
    parameter int                        RESP_LATENCY   = 1
) (
    input  logic             obi_aclk,
    input  logic             obi_aresetn,
    obi_slave_mem_if.slave   obi_slave
);

    localparam int                    IDX_W = $clog2(MEM_WORDS);
    localparam logic [WAIT_CNT_W-1:0] WS_C  = WAIT_CNT_W'(WAIT_STATES);

    wait_state_e           state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  gnt;
    logic                  accept;
    logic                  in_range;
    logic [IDX_W-1:0]      idx;
    logic [31:0]           mem_q [MEM_WORDS];
    resp_t                 resp_in, resp_out;
    logic                  unused_addr_lsb;

    always_ff @(posedge obi_aclk or negedge obi_aresetn) begin
        if (!obi_aresetn) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Any cycle without a pending, ungranted request returns the counter to idle.
    always_comb begin
        state_d    = ST_IDLE;
        wait_cnt_d = '0;
        gnt        = 1'b0;
        if (obi_slave.req) begin
            gnt = (state_q == ST_IDLE) ? (WS_C == '0) : (wait_cnt_q == WS_C);
            if (!gnt) begin
                state_d    = ST_WAIT;
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
    end

    assign obi_slave.gnt = gnt;
    assign accept        = obi_slave.req && gnt;

    // BASE_ADDR is aligned to the memory size, so matching the upper bits is the range check.
    assign in_range        = (obi_slave.addr[OBI_ADDR_WIDTH-1:IDX_W+2] == BASE_ADDR[OBI_ADDR_WIDTH-1:IDX_W+2]);
    assign idx             = obi_slave.addr[IDX_W+1:2];
    assign unused_addr_lsb = ^obi_slave.addr[1:0];

    always_ff @(posedge obi_aclk or negedge obi_aresetn) begin
        if (!obi_aresetn) begin
            for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
        end else if (accept && obi_slave.we && in_range) begin
            for (int b = 0; b < OBI_BE_W; b++) begin
                if (obi_slave.be[b]) mem_q[idx][8*b +: 8] <= obi_slave.w_data[8*b +: 8];
            end
        end
    end

    // Reads sample the array before this edge's write, so a write one cycle earlier is visible.
    always_comb begin
        resp_in       = '0;
        resp_in.valid = accept;
        resp_in.data  = OBI_ERR_DATA;
        resp_in.err   = accept && !in_range;
        if (accept && !obi_slave.we && in_range) resp_in.data = mem_q[idx];
    end

    obi_resp_pipe #(
        .LATENCY (RESP_LATENCY)
    ) u_resp_pipe (
        .clk_i  (obi_aclk),
        .rst_ni (obi_aresetn),
        .resp_i (resp_in),
        .resp_o (resp_out)
    );

    assign obi_slave.r_valid = resp_out.valid;
    assign obi_slave.r_data  = resp_out.data;
    assign obi_slave.r_err   = resp_out.err;

endmodule

// File: tb/tb_obi_slave_mem.sv
// Directed bench: three responders with different wait-state / latency settings share one stimulus bus.
module tb_obi_slave_mem;
    import obi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0, req_c = 1'b0;
    logic [31:0] addr_s = '0, wdata_s = '0;
    logic        we_s = 1'b0;
    logic [3:0]  be_s = '0;
    logic [1:0]  sel = 2'd0;

    logic        gnt_s, rvalid_s, rerr_s;
    logic [31:0] rdata_s;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    obi_slave_mem_if #(.OBI_ADDR_WIDTH(32), .OBI_DATA_WIDTH(32)) if_a ();
    obi_slave_mem_if #(.OBI_ADDR_WIDTH(32), .OBI_DATA_WIDTH(32)) if_b ();
    obi_slave_mem_if #(.OBI_ADDR_WIDTH(32), .OBI_DATA_WIDTH(32)) if_c ();

    assign if_a.req = req_a;  assign if_a.addr = addr_s;  assign if_a.we = we_s;
    assign if_a.w_data = wdata_s;  assign if_a.be = be_s;
    assign if_b.req = req_b;  assign if_b.addr = addr_s;  assign if_b.we = we_s;
    assign if_b.w_data = wdata_s;  assign if_b.be = be_s;
    assign if_c.req = req_c;  assign if_c.addr = addr_s;  assign if_c.we = we_s;
    assign if_c.w_data = wdata_s;  assign if_c.be = be_s;

    obi_slave_mem #(.MEM_WORDS(256), .BASE_ADDR(32'h0), .WAIT_STATES(0), .RESP_LATENCY(1))
        dut_a (.obi_aclk(clk), .obi_aresetn(rst_n), .obi_slave(if_a));
    obi_slave_mem #(.MEM_WORDS(256), .BASE_ADDR(32'h0), .WAIT_STATES(3), .RESP_LATENCY(1))
        dut_b (.obi_aclk(clk), .obi_aresetn(rst_n), .obi_slave(if_b));
    obi_slave_mem #(.MEM_WORDS(256), .BASE_ADDR(32'h0), .WAIT_STATES(0), .RESP_LATENCY(3))
        dut_c (.obi_aclk(clk), .obi_aresetn(rst_n), .obi_slave(if_c));

    always_comb begin
        gnt_s = if_a.gnt; rvalid_s = if_a.r_valid; rdata_s = if_a.r_data; rerr_s = if_a.r_err;
        case (sel)
            2'd1: begin gnt_s = if_b.gnt; rvalid_s = if_b.r_valid; rdata_s = if_b.r_data; rerr_s = if_b.r_err; end
            2'd2: begin gnt_s = if_c.gnt; rvalid_s = if_c.r_valid; rdata_s = if_c.r_data; rerr_s = if_c.r_err; end
            default: ;
        endcase
    end

    task automatic set_req(input logic v);
        case (sel)
            2'd1:    req_b = v;
            2'd2:    req_c = v;
            default: req_a = v;
        endcase
    endtask

    // One request on the selected responder: returns grant wait cycles, response latency and payload.
    task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be,
                        output int wc, output int lat, output logic [31:0] rd, output logic er);
        @(posedge clk); #1;
        we_s = we; addr_s = addr; wdata_s = wd; be_s = be;
        set_req(1'b1);
        wc = 0;
        #1;
        while (!gnt_s && wc < 50) begin
            @(posedge clk); #2;
            wc++;
        end
        @(posedge clk); #1;
        set_req(1'b0);
        lat = 1;
        while (!rvalid_s && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rdata_s; er = rerr_s;
    endtask

    task automatic test_reset();
        sel = 2'd0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (if_a.gnt !== 1'b0) begin tests_failed++; $display("FAIL reset_gnt got %b want 0", if_a.gnt); end
        tests_run++; if (if_a.r_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rvalid got %b want 0", if_a.r_valid); end
        tests_run++; if (if_a.r_data !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata got %h want 0", if_a.r_data); end
        tests_run++; if (if_a.r_err !== 1'b0) begin tests_failed++; $display("FAIL reset_rerr got %b want 0", if_a.r_err); end
        tests_run++; if (if_c.r_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rvalid_c got %b want 0", if_c.r_valid); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int wc, lat; logic [31:0] rd; logic er;
        sel = 2'd0;
        xfer(1'b1, 32'h10, 32'hA5A5_1234, 4'hF, wc, lat, rd, er);
        tests_run++; if (wc !== 0) begin tests_failed++; $display("FAIL basic_wr_wait got %0d want 0", wc); end
        tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL basic_wr_lat got %0d want 1", lat); end
        tests_run++; if (rd !== 32'h0 || er !== 1'b0) begin tests_failed++; $display("FAIL basic_wr_resp got %h/%b want 0/0", rd, er); end
        xfer(1'b0, 32'h10, 32'h0, 4'hF, wc, lat, rd, er);
        tests_run++; if (wc !== 0) begin tests_failed++; $display("FAIL basic_rd_wait got %0d want 0", wc); end
        tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL basic_rd_lat got %0d want 1", lat); end
        tests_run++; if (rd !== 32'hA5A5_1234) begin tests_failed++; $display("FAIL basic_rd_data got %h want a5a51234", rd); end
        tests_run++; if (er !== 1'b0) begin tests_failed++; $display("FAIL basic_rd_err got %b want 0", er); end
    endtask

    task automatic test_byte_en();
        int wc, lat; logic [31:0] rd; logic er;
        sel = 2'd0;
        xfer(1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF, wc, lat, rd, er);
        xfer(1'b1, 32'h0, 32'h1122_3344, 4'b0101, wc, lat, rd, er);
        xfer(1'b0, 32'h0, 32'h0, 4'h0, wc, lat, rd, er);
        tests_run++; if (rd !== 32'hFF22_FF44) begin tests_failed++; $display("FAIL be_partial got %h want ff22ff44", rd); end
        xfer(1'b1, 32'h2, 32'hDEAD_BEEF, 4'b0000, wc, lat, rd, er);
        tests_run++; if (er !== 1'b0 || lat !== 1) begin tests_failed++; $display("FAIL be_zero_resp got err %b lat %0d want 0/1", er, lat); end
        xfer(1'b0, 32'h3, 32'h0, 4'b0001, wc, lat, rd, er);
        tests_run++; if (rd !== 32'hFF22_FF44) begin tests_failed++; $display("FAIL be_zero_keep got %h want ff22ff44", rd); end
    endtask

    task automatic test_wait_states();
        int wc, lat, seen; logic [31:0] rd; logic er;
        sel = 2'd1;
        xfer(1'b0, 32'h4, 32'h0, 4'hF, wc, lat, rd, er);
        tests_run++; if (wc !== 3) begin tests_failed++; $display("FAIL ws_wait got %0d want 3", wc); end
        tests_run++; if (lat !== 1 || rd !== 32'h0 || er !== 1'b0) begin tests_failed++; $display("FAIL ws_resp got lat %0d %h/%b want 1 0/0", lat, rd, er); end
        // Abandon a request after two cycles.
        @(posedge clk); #1;
        we_s = 1'b1; addr_s = 32'h8; wdata_s = 32'h5555_AAAA; be_s = 4'hF;
        req_b = 1'b1;
        #1;
        tests_run++; if (gnt_s !== 1'b0) begin tests_failed++; $display("FAIL ws_abort_gnt0 got %b want 0", gnt_s); end
        @(posedge clk); #2;
        tests_run++; if (gnt_s !== 1'b0) begin tests_failed++; $display("FAIL ws_abort_gnt1 got %b want 0", gnt_s); end
        @(posedge clk); #1;
        req_b = 1'b0;
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (rvalid_s) seen++;
        end
        tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL ws_abort_rvalid got %0d want 0", seen); end
        xfer(1'b0, 32'h8, 32'h0, 4'hF, wc, lat, rd, er);
        tests_run++; if (wc !== 3) begin tests_failed++; $display("FAIL ws_rewait got %0d want 3", wc); end
        tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL ws_abort_nowrite got %h want 0", rd); end
    endtask

    task automatic test_out_of_range();
        int wc, lat; logic [31:0] rd; logic er;
        sel = 2'd0;
        xfer(1'b1, 32'h400, 32'h1234_5678, 4'hF, wc, lat, rd, er);
        tests_run++; if (er !== 1'b1 || rd !== 32'h0) begin tests_failed++; $display("FAIL oor_wr_resp got %h/%b want 0/1", rd, er); end
        xfer(1'b0, 32'h0, 32'h0, 4'hF, wc, lat, rd, er);
        tests_run++; if (rd !== 32'hFF22_FF44) begin tests_failed++; $display("FAIL oor_wr_nochange got %h want ff22ff44", rd); end
        xfer(1'b0, 32'h400, 32'h0, 4'hF, wc, lat, rd, er);
        tests_run++; if (er !== 1'b1 || rd !== 32'h0) begin tests_failed++; $display("FAIL oor_rd_resp got %h/%b want 0/1", rd, er); end
        xfer(1'b1, 32'h3FC, 32'hCAFE_F00D, 4'hF, wc, lat, rd, er);
        xfer(1'b0, 32'h3FC, 32'h0, 4'hF, wc, lat, rd, er);
        tests_run++; if (er !== 1'b0 || rd !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL top_word got %h/%b want cafef00d/0", rd, er); end
    endtask

    task automatic test_back_to_back();
        int wc, lat; logic [31:0] rd; logic er;
        logic [31:0] exp_d;
        logic        exp_v;
        sel = 2'd2;
        for (int i = 0; i < 4; i++) begin
            xfer(1'b1, 32'(4 * i), 32'(i + 1), 4'hF, wc, lat, rd, er);
        end
        tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL b2b_wr_lat got %0d want 3", lat); end
        @(posedge clk); #1;
        we_s = 1'b0; be_s = 4'hF; addr_s = 32'h0; req_c = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            if (k < 3) addr_s = 32'(4 * (k + 1));
            else req_c = 1'b0;
            exp_v = (k >= 2 && k <= 5);
            exp_d = exp_v ? 32'(k - 1) : 32'h0;
            tests_run++;
            if (rvalid_s !== exp_v || rdata_s !== exp_d) begin
                tests_failed++;
                $display("FAIL b2b_cycle%0d got %b/%h want %b/%h", k, rvalid_s, rdata_s, exp_v, exp_d);
            end
        end
    endtask

    task automatic test_reset_inflight();
        int wc, lat, seen; logic [31:0] rd; logic er;
        sel = 2'd2;
        @(posedge clk); #1;
        we_s = 1'b0; be_s = 4'hF; addr_s = 32'h8; req_c = 1'b1;
        @(posedge clk); #1;
        addr_s = 32'hC;
        @(posedge clk); #1;
        req_c = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++; if (if_c.r_valid !== 1'b0 || if_c.r_data !== 32'h0) begin tests_failed++; $display("FAIL rst_flight_now got %b/%h want 0/0", if_c.r_valid, if_c.r_data); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (if_c.r_valid) seen++;
        end
        tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL rst_flight_stale got %0d want 0", seen); end
        xfer(1'b0, 32'h8, 32'h0, 4'hF, wc, lat, rd, er);
        tests_run++; if (rd !== 32'h0 || lat !== 3) begin tests_failed++; $display("FAIL rst_mem_clear got %h lat %0d want 0 lat 3", rd, lat); end
        sel = 2'd0;
        xfer(1'b0, 32'h10, 32'h0, 4'hF, wc, lat, rd, er);
        tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL rst_mem_clear_a got %h want 0", rd); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_en();
        test_wait_states();
        test_out_of_range();
        test_back_to_back();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
